uart_tx: RTL and testbench

- 8N1 UART transmitter: serialises a parallel byte onto `txd`.
- Bit period and framing match the team's existing `uart_rx` block:
  - idle-high line, one low start bit
  - DATA_BITS data bits, LSB first
  - one high stop bit
  - each bit CLKS_PER_BIT clock cycles long
- Sits on the system side of the UART pair. A host loads a byte with a single-cycle request and is told when the frame has left the line.
- Contains its own baud counter, a framing FSM, a shift register and a busy/done handshake.

---
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (idle high, start bit, DATA_BITS data bits LSB first, stop bit); registered outputs.
// Define UART_TX_PARITY_EN to insert a parity bit before the stop bit; PARITY_ODD selects its sense.
module uart_tx #(
   parameter int CLKS_PER_BIT = 201,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx: illegal parameter value");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state, state_n;
   logic [CW-1:0]        baud_cnt, baud_cnt_n;
   logic [BW-1:0]        bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 txd_n, tx_busy_n, tx_done_n;
   logic                 bit_end;

   assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

`ifdef UART_TX_PARITY_EN
   // Parity is taken from the byte as accepted, so later tx_data changes cannot disturb it.
   logic parity;
   always_ff @(posedge clk) begin
      if (reset)
         parity <= 1'b0;
      else if (state == IDLE && tx_start)
         parity <= (^tx_data) ^ 1'(PARITY_ODD);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shift    <= shift_n;
         txd      <= txd_n;
         tx_busy  <= tx_busy_n;
         tx_done  <= tx_done_n;
      end
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift;
      txd_n      = txd;
      tx_busy_n  = tx_busy;
      tx_done_n  = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            txd_n      = 1'b1;
            tx_busy_n  = 1'b0;
            if (tx_start) begin
               shift_n   = tx_data;
               bit_cnt_n = '0;
               state_n   = START;
               txd_n     = 1'b0;
               tx_busy_n = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               txd_n   = shift[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_n   = shift >> 1;
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  txd_n   = parity;
`else
                  state_n = STOP;
                  txd_n   = 1'b1;
`endif
               end else begin
                  // next bit is shift[1] because the shift lands on this same edge
                  txd_n = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               txd_n   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_n   = IDLE;
               txd_n     = 1'b1;
               tx_busy_n = 1'b0;
               tx_done_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus for uart_tx, checked every cycle against a frame-level model
// plus a mid-bit sampling receiver and hand-computed literal expectations.
module tb_uart_tx;
   localparam int CPB  = 201;
   localparam int DB   = 8;
   localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = DB + 3;
`else
   localparam int NBITS = DB + 2;
`endif
   localparam int FRAME = NBITS * CPB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tx_start = 1'b0;
   logic [DB-1:0] tx_data = '0;
   logic          txd, tx_busy, tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
      .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
      .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Line level for bit slot k of a frame carrying d.
   function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= DB) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == DB + 1) return (^d) ^ 1'(PODD);
`endif
      return 1'b1;
   endfunction

   // Frame-level model: remembers when the last frame was accepted and what it carried.
   int            cyc = 0;
   bit            armed = 0;
   bit            active = 0;
   int            fstart = 0;
   logic [DB-1:0] fdata = '0;

   always @(posedge clk) begin
      bit busy_old;
      busy_old = active && ((cyc - fstart) < FRAME);
      cyc++;
      if (reset) begin
         armed  = 1;
         active = 0;
      end else if (armed && tx_start && !busy_old) begin
         active = 1;
         fstart = cyc;
         fdata  = tx_data;
      end
   end

   always @(negedge clk) begin
      logic ex_txd, ex_busy, ex_done;
      int   off;
      if (armed) begin
         ex_txd  = 1'b1;
         ex_busy = 1'b0;
         ex_done = 1'b0;
         if (active) begin
            off = cyc - fstart;
            if (off < FRAME) begin
               ex_txd  = frame_bit(fdata, off / CPB);
               ex_busy = 1'b1;
            end else if (off == FRAME) begin
               ex_done = 1'b1;
            end
         end
         chk("model_txd", txd, ex_txd);
         chk("model_busy", tx_busy, ex_busy);
         chk("model_done", tx_done, ex_done);
      end
   end

   // Pulse counter and mid-bit sampling receiver on txd.
   int            dones = 0;
   int            rx_cnt = -1;
   logic [DB-1:0] rx_sh = '0;
   logic [DB-1:0] rx_last = '0;

   always @(negedge clk) begin
      int k;
      if (armed) begin
         if (tx_done === 1'b1) dones++;
         if (rx_cnt < 0) begin
            if (txd === 1'b0) rx_cnt = 0;
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               k = rx_cnt / CPB;
               if (k >= 1 && k <= DB) rx_sh[k-1] = txd;
               else if (k == NBITS - 1) begin
                  rx_last = rx_sh;
                  rx_cnt  = -1;
               end
            end
         end
      end
   end

   task automatic wait_off(input int acc, input int off);
      while (cyc - acc < off) @(negedge clk);
   endtask

   task automatic send(input logic [DB-1:0] d, output int acc);
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = ~d;
      acc      = cyc;
   endtask

   initial begin
      int            acc, acc2, d0;
      logic [NBITS-1:0] lit;
      logic [DB-1:0] lb [3];
      lb = '{8'h5A, 8'h00, 8'hFF};

      // reset held with tx_start high
      reset    = 1'b1;
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_txd", txd, 1'b1);
         chk("rst_busy", tx_busy, 1'b0);
         chk("rst_done", tx_done, 1'b0);
      end
      reset    = 1'b0;
      tx_start = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_txd", txd, 1'b1);
      chk("post_rst_busy", tx_busy, 1'b0);

      // A5: literal bit sequence, LSB first
`ifdef UART_TX_PARITY_EN
      lit = 11'b1_0_1010_0101_0;
`else
      lit = 10'b1_1010_0101_0;
`endif
      send(8'hA5, acc);
      for (int k = 0; k < NBITS; k++) begin
         wait_off(acc, k * CPB);
         chk("a5_bit_first", txd, lit[k]);
         wait_off(acc, k * CPB + CPB - 1);
         chk("a5_bit_last", txd, lit[k]);
      end
      wait_off(acc, FRAME - 1);
      chk("a5_done_early", tx_done, 1'b0);
      chk("a5_busy_last", tx_busy, 1'b1);
      wait_off(acc, FRAME);
      chk("a5_done", tx_done, 1'b1);
      chk("a5_busy_fall", tx_busy, 1'b0);
      wait_off(acc, FRAME + 1);
      chk("a5_done_once", tx_done, 1'b0);
      chk("a5_rx", rx_last, 8'hA5);

      // busy rejection
      d0 = dones;
      send(8'h3C, acc);
      wait_off(acc, 500);
      tx_start = 1'b1;
      tx_data  = 8'hFF;
      @(negedge clk);
      tx_start = 1'b0;
      wait_off(acc, FRAME + 20);
      chk("rej_dones", dones - d0, 1);
      chk("rej_rx", rx_last, 8'h3C);
      chk("rej_idle", tx_busy, 1'b0);

      // back-to-back from the done cycle
      send(8'h00, acc);
      wait_off(acc, (NBITS - 1) * CPB - 1);
      chk("b2b_pre_stop", txd, 1'b0);
      wait_off(acc, (NBITS - 1) * CPB);
      chk("b2b_stop_first", txd, 1'b1);
      wait_off(acc, FRAME - 1);
      chk("b2b_stop_last", txd, 1'b1);
      wait_off(acc, FRAME);
      chk("b2b_done", tx_done, 1'b1);
      chk("b2b_rx0", rx_last, 8'h00);
      tx_start = 1'b1;
      tx_data  = 8'h81;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'h7E;
      acc2     = cyc;
      chk("b2b_start_bit", txd, 1'b0);
      chk("b2b_busy", tx_busy, 1'b1);
      wait_off(acc2, FRAME + 2);
      chk("b2b_rx1", rx_last, 8'h81);

      // loopback through the sampling receiver
      foreach (lb[i]) begin
         d0 = dones;
         send(lb[i], acc);
         wait_off(acc, FRAME + 2);
         chk("loop_rx", rx_last, lb[i]);
         chk("loop_dones", dones - d0, 1);
      end

      // reset mid-frame
      d0 = dones;
      send(8'hE7, acc);
      wait_off(acc, 1000);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_txd", txd, 1'b1);
      chk("abort_busy", tx_busy, 1'b0);
      chk("abort_done", tx_done, 1'b0);
      reset = 1'b0;
      repeat (2100) @(negedge clk);
      chk("abort_no_done", dones - d0, 0);
      send(8'hC3, acc);
      wait_off(acc, FRAME + 2);
      chk("abort_rx", rx_last, 8'hC3);
      chk("abort_dones", dones - d0, 1);

`ifdef UART_TX_PARITY_EN
      // 07 has three ones: even parity bit 1, odd parity bit 0
      send(8'h07, acc);
      wait_off(acc, (DB + 1) * CPB + CPB / 2);
      chk("par07_bit", txd, PODD ? 1'b0 : 1'b1);
      wait_off(acc, 2210);
      chk("par07_done_early", tx_done, 1'b0);
      wait_off(acc, 2211);
      chk("par07_done", tx_done, 1'b1);
      wait_off(acc, 2213);
      chk("par07_rx", rx_last, 8'h07);
`endif

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
